switch_nport: RTL



---
 rtl/switch_nport_if.sv | 32 +++
 rtl/switch_nport.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/switch_nport_if.sv
// switch_nport bus bundle: packet input, config port,
// per-port FIFO read side and drop counter.
interface switch_nport_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                        data_status;
  logic [DATA_W-1:0]           data;
  logic                        mem_en;
  logic                        mem_rd_wr;
  logic [PORT_W-1:0]           mem_add;
  logic [DATA_W-1:0]           mem_data;
  logic [DATA_W-1:0]           mem_rdata;
  logic [NUM_PORTS-1:0]        ready;
  logic [NUM_PORTS-1:0]        read;
  logic [NUM_PORTS*DATA_W-1:0] port_data;
  logic [15:0]                 drop_cnt;

  modport master (
    output data_status, data, mem_en, mem_rd_wr,
    output mem_add, mem_data, read,
    input  mem_rdata, ready, port_data, drop_cnt
  );

  modport slave (
    input  data_status, data, mem_en, mem_rd_wr,
    input  mem_add, mem_data, read,
    output mem_rdata, ready, port_data, drop_cnt
  );
endinterface

// File: rtl/switch_nport.sv
// N-port byte-serial packet switch: DA lookup against
// programmable port addresses, per-port output FIFOs.
module switch_nport #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  switch_nport_if.slave  sw
);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [PORT_W-1:0]  dest_q, dest_d;
  logic [15:0]        drop_q, drop_d;
  logic [DATA_W-1:0]  addr_q [NUM_PORTS];
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt_q  [NUM_PORTS];
  logic [DATA_W-1:0]  pd_q   [NUM_PORTS];

  logic                 hit;
  logic [PORT_W-1:0]    hit_idx;
  logic [PORT_W-1:0]    tgt;
  logic                 can_wr;
  logic                 push_en;
  logic                 drop_inc;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  // Lowest-index port whose address matches the current byte
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (addr_q[i] == sw.data) begin
        hit     = 1'b1;
        hit_idx = PORT_W'(i);
      end
    end
  end

  // Pops honour only non-empty FIFOs
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i] = sw.read[i] && (cnt_q[i] != '0);
    end
  end

  // A write fits if there is room or the same FIFO pops now
  always_comb begin
    tgt    = (state_q == S_IDLE) ? hit_idx : dest_q;
    can_wr = (cnt_q[tgt] < CNT_W'(FIFO_DEPTH)) || pop[tgt];
  end

  // Packet FSM: next state, push and drop decisions
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    push_en  = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sw.data_status) begin
          if (hit && can_wr) begin
            dest_d  = hit_idx;
            push_en = 1'b1;
            state_d = S_FWD;
          end else begin
            drop_inc = 1'b1;
            state_d  = S_DROP;
          end
        end
      end
      S_FWD: begin
        if (!sw.data_status) begin
          state_d = S_IDLE;
        end else if (can_wr) begin
          push_en = 1'b1;
        end else begin
          drop_inc = 1'b1;
          state_d  = S_DROP;
        end
      end
      S_DROP: begin
        if (!sw.data_status) state_d = S_IDLE;
      end
      default: state_d = S_DROP;
    endcase
  end

  // Steer the accepted byte to its FIFO
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      push[i] = push_en && (tgt == PORT_W'(i));
    end
  end

  // Drop counter sticks at all-ones
  always_comb begin
    drop_d = drop_q;
    if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // FSM state; reset parks in DROP so an in-flight packet is ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_DROP;
      dest_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      drop_q  <= drop_d;
    end
  end

  // Config registers and registered readback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) addr_q[i] <= DATA_W'(i);
      rdata_q <= '0;
    end else if (sw.mem_en) begin
      if (sw.mem_rd_wr) begin
        if (int'(sw.mem_add) < NUM_PORTS) addr_q[sw.mem_add] <= sw.mem_data;
      end else begin
        rdata_q <= (int'(sw.mem_add) < NUM_PORTS) ? addr_q[sw.mem_add] : '0;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;

    // Pointers, occupancy and the last popped byte
    always_ff @(posedge clk) begin
      if (reset) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        cnt_q[g] <= '0;
        pd_q[g]  <= '0;
      end else begin
        if (push[g]) wptr_q <= wptr_q + PTR_W'(1);
        if (pop[g]) begin
          rptr_q  <= rptr_q + PTR_W'(1);
          pd_q[g] <= mem_q[rptr_q];
        end
        unique case ({push[g], pop[g]})
          2'b10:   cnt_q[g] <= cnt_q[g] + CNT_W'(1);
          2'b01:   cnt_q[g] <= cnt_q[g] - CNT_W'(1);
          default: cnt_q[g] <= cnt_q[g];
        endcase
      end
    end

    // Storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
      if (push[g]) mem_q[wptr_q] <= sw.data;
    end

    assign sw.ready[g]                       = (cnt_q[g] != '0);
    assign sw.port_data[g*DATA_W +: DATA_W] = pd_q[g];
  end

  assign sw.mem_rdata = rdata_q;
  assign sw.drop_cnt  = drop_q;

endmodule
